bht_update_queue: RTL and testbench
===================================

Name: bht_update_queue

Overview:
- In-order tracker for conditional branches in flight between instruction-queue dispatch and ROB commit.
- Drives the branch-history-table update port:
  - "predict wrong" pulse, "predict correct" pulse, table index.
- Also drives the pipeline mispredict flush and redirect PC.
- Entries are allocated at dispatch, resolved out of order by the ALU, and retired strictly in allocation order.

Parameters:
- DEPTH, 16, number of tracked branches; power of two.
- TAG_W, 4, log2(DEPTH); entry tag width.
- BHT_W, 8, predictor-table index width; must match the predictor.
- ADDR_W, 32, PC width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; low freezes all state
- alloc_valid  in  1  dispatch pushes one branch
- alloc_bht_id  in  BHT_W  predictor index used for this branch
- alloc_pred_taken  in  1  prediction made at fetch
- alloc_alt_pc  in  ADDR_W  PC to fetch if the prediction proves wrong
- alloc_ready  out  1  queue can accept (count<DEPTH)
- alloc_tag  out  TAG_W  tag assigned to the pushed entry (= tail pointer)
- res_valid  in  1  ALU reports a branch outcome
- res_tag  in  TAG_W  entry being resolved
- res_taken  in  1  actual outcome
- upd_wrong  out  1  one-cycle pulse: predictor index mispredicted
- upd_right  out  1  one-cycle pulse: predictor index predicted correctly
- upd_bht_id  out  BHT_W  index for upd_wrong/upd_right
- flush  out  1  one-cycle pulse: squash all younger work
- redirect_pc  out  ADDR_W  fetch target, valid with flush
- count  out  TAG_W+1  occupied entries

Behaviour:
- Reset:
  - head=tail=0, count=0, all valid/resolved bits 0.
  - upd_wrong=upd_right=flush=0, upd_bht_id=0, redirect_pc=0.
  - A reset mid-operation discards every entry without emitting updates.
- rdy=0:
  - No push, resolve or pop.
  - All pulse outputs are 0 in the following cycle.
  - Pointers and entries are held.
- Allocation:
  - A push occurs at an edge where alloc_valid && alloc_ready.
  - The entry at tail is written with {bht_id, pred_taken, alt_pc}, valid=1, resolved=0.
  - tail increments modulo DEPTH.
  - alloc_ready is computed from the registered count only. When full, a same-edge pop does not enable a push.
- Resolution:
  - A resolve occurs at an edge where res_valid, the entry at res_tag is valid, and it is not yet resolved. It sets resolved=1 and stores actual=res_taken.
  - A resolve of an invalid or already-resolved entry is ignored.
- Commit:
  - A pop occurs at an edge where head is valid and resolved as of the previous edge. There is no same-edge forwarding of resolution.
  - Latency: res_valid in cycle k gives an update pulse in cycle k+2 at the earliest.
  - At most one pop per edge; the popped entry is cleared and head advances modulo DEPTH.
  - Registered outputs for the cycle after the pop:
    - upd_bht_id = entry.bht_id.
    - upd_right = (actual==pred_taken).
    - upd_wrong = !upd_right.
- Mispredict:
  - On a wrong pop, flush=1 and redirect_pc=entry.alt_pc for one cycle.
  - At the same edge all entries are invalidated, head=tail=0 and count=0.
  - A push or resolve coinciding with that edge is discarded as wrong-path.
- Simultaneous push+pop (correct) in one edge: count unchanged.
- Count: width TAG_W+1, range 0..DEPTH. Wrap-around of pointers is silent.
- Exactly one of upd_wrong/upd_right is high in any cycle, or neither.

Decomposition:
- Shared package holds:
  - BHT_W (shared with the predictor table).
  - DEPTH/TAG_W.
  - The entry struct {valid, resolved, actual, pred_taken, bht_id, alt_pc}.
- Single module; no sub-module warranted. Entry storage is a register array inside the block.

Test Plan:
- Reset then push bht_id=0x12, pred=1, alt_pc=0x100. Resolve tag0 taken=1 in cycle 3. Required: upd_right=1, upd_bht_id=0x12 in cycle 5; flush=0; count returns to 0.
- Push 3 branches (tags 0,1,2); resolve in order 2,1,0. Required: no pops until tag0 is resolved, then one update per cycle in tag order 0,1,2.
- Push tags 0,1,2 with pred=0; resolve tag0 taken=1 with alt_pc=0x2000. Required:
  - upd_wrong=1 and flush=1 with redirect_pc=0x2000 in the same cycle.
  - count=0 next cycle.
  - A later resolve of tag1 produces no update.
- Push 16 branches. Required: alloc_ready=0 and count=16; a 17th alloc_valid is not accepted. Resolve tag0: after the pop alloc_ready=1, the next push gets tag0 (wrap).
- Resolve pending with rdy=0 for 4 cycles. Required: no pulses and state unchanged; after rdy=1, normal k+2 update timing resumes.
- Mispredict pop coinciding with alloc_valid. Required: the new branch is discarded and count=0. Separately, assert rst while 5 entries are pending: all outputs 0 and no updates emitted afterwards.

Source files
------------

// File: rtl/bht_update_queue_pkg.sv
// Shared definitions for the branch-history-table update queue.
// Holds the queue geometry, the predictor index width (must match the
// predictor table) and the per-entry record layout.
package bht_update_queue_pkg;

  localparam int DEPTH  = 16;             // tracked branches, power of two
  localparam int TAG_W  = $clog2(DEPTH);  // entry tag / pointer width
  localparam int BHT_W  = 8;              // predictor-table index width
  localparam int ADDR_W = 32;             // PC width

  typedef struct packed {
    logic              valid;       // entry allocated
    logic              resolved;    // ALU outcome received
    logic              actual;      // outcome reported by the ALU
    logic              pred_taken;  // prediction made at fetch
    logic [BHT_W-1:0]  bht_id;      // predictor index to update
    logic [ADDR_W-1:0] alt_pc;      // fetch target if prediction was wrong
  } entry_t;

endpackage

// File: rtl/bht_update_queue.sv
// In-order tracker for conditional branches between dispatch and commit.
// Branches are pushed at the tail, resolved out of order by tag, and
// popped strictly from the head once resolved. Each pop produces a
// one-cycle predictor update pulse; a mispredicted pop also flushes the
// pipeline, redirects fetch and empties the whole queue.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable; low freezes all state, pulses go low
//   alloc_valid/_bht_id/_pred_taken/_alt_pc   dispatch push
//   alloc_ready       room for a push (from registered count only)
//   alloc_tag         tag the next push will receive (tail pointer)
//   res_valid/_tag/_taken                     ALU resolution
//   upd_wrong/upd_right/upd_bht_id            predictor update (registered)
//   flush/redirect_pc                         mispredict recovery (registered)
//   count             occupied entries, 0..DEPTH
module bht_update_queue
  import bht_update_queue_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              alloc_valid,
  input  logic [BHT_W-1:0]  alloc_bht_id,
  input  logic              alloc_pred_taken,
  input  logic [ADDR_W-1:0] alloc_alt_pc,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              res_valid,
  input  logic [TAG_W-1:0]  res_tag,
  input  logic              res_taken,
  output logic              upd_wrong,
  output logic              upd_right,
  output logic [BHT_W-1:0]  upd_bht_id,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [TAG_W:0]    count
);

  entry_t           entries [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;

  entry_t head_entry;
  logic   push;
  logic   res_hit;
  logic   pop;
  logic   pop_wrong;

  assign alloc_ready = (count < (TAG_W+1)'(DEPTH));
  assign alloc_tag   = tail;

  // Pop decision looks only at registered entry state, so a resolution
  // landing this edge cannot pop until the following edge.
  always_comb begin
    head_entry = entries[head];
    push       = rdy && alloc_valid && alloc_ready;
    res_hit    = rdy && res_valid && entries[res_tag].valid && !entries[res_tag].resolved;
    pop        = rdy && head_entry.valid && head_entry.resolved;
    pop_wrong  = pop && (head_entry.actual != head_entry.pred_taken);
  end

  // Pointers, occupancy and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      upd_wrong   <= 1'b0;
      upd_right   <= 1'b0;
      upd_bht_id  <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      upd_wrong <= 1'b0;
      upd_right <= 1'b0;
      flush     <= 1'b0;
      if (pop) begin
        upd_bht_id <= head_entry.bht_id;
        upd_right  <= !pop_wrong;
        upd_wrong  <= pop_wrong;
      end
      if (pop_wrong) begin
        // Everything younger is wrong-path, including a same-edge push.
        flush       <= 1'b1;
        redirect_pc <= head_entry.alt_pc;
        head        <= '0;
        tail        <= '0;
        count       <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        count <= count + (TAG_W+1)'(push) - (TAG_W+1)'(pop);
      end
    end
  end

  // Entry storage. Push, resolve and pop never target the same slot in
  // one edge: push hits an invalid slot, resolve needs a valid unresolved
  // one, pop needs a valid resolved one.
  always_ff @(posedge clk) begin
    if (rst || pop_wrong) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && tail == TAG_W'(i)) begin
          entries[i].valid      <= 1'b1;
          entries[i].resolved   <= 1'b0;
          entries[i].actual     <= 1'b0;
          entries[i].pred_taken <= alloc_pred_taken;
          entries[i].bht_id     <= alloc_bht_id;
          entries[i].alt_pc     <= alloc_alt_pc;
        end
        if (res_hit && res_tag == TAG_W'(i)) begin
          entries[i].resolved <= 1'b1;
          entries[i].actual   <= res_taken;
        end
        if (pop && head == TAG_W'(i)) begin
          entries[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bht_update_queue.sv
// Directed bench for bht_update_queue with hand-computed expectations.
module tb_bht_update_queue;
  import bht_update_queue_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rdy = 1'b1;
  logic              alloc_valid = 1'b0;
  logic [BHT_W-1:0]  alloc_bht_id = '0;
  logic              alloc_pred_taken = 1'b0;
  logic [ADDR_W-1:0] alloc_alt_pc = '0;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              res_valid = 1'b0;
  logic [TAG_W-1:0]  res_tag = '0;
  logic              res_taken = 1'b0;
  logic              upd_wrong;
  logic              upd_right;
  logic [BHT_W-1:0]  upd_bht_id;
  logic              flush;
  logic [ADDR_W-1:0] redirect_pc;
  logic [TAG_W:0]    count;

  int total = 0;
  int bad   = 0;

  bht_update_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_bht_id(alloc_bht_id),
    .alloc_pred_taken(alloc_pred_taken), .alloc_alt_pc(alloc_alt_pc),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
    .upd_wrong(upd_wrong), .upd_right(upd_right), .upd_bht_id(upd_bht_id),
    .flush(flush), .redirect_pc(redirect_pc), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Inputs set before tick are sampled at the edge; outputs read after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [BHT_W-1:0] id, input logic pred, input logic [ADDR_W-1:0] alt);
    alloc_valid      = 1'b1;
    alloc_bht_id     = id;
    alloc_pred_taken = pred;
    alloc_alt_pc     = alt;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic resolve(input logic [TAG_W-1:0] tag, input logic taken);
    res_valid = 1'b1;
    res_tag   = tag;
    res_taken = taken;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_right"}, 64'(upd_right), 64'd0);
    check({tag, "_wrong"}, 64'(upd_wrong), 64'd0);
    check({tag, "_flush"}, 64'(flush), 64'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(alloc_ready), 64'd1);
    check("rst_tag", 64'(alloc_tag), 64'd0);
    check_quiet("rst");
    check("rst_bht_id", 64'(upd_bht_id), 64'd0);
    check("rst_redirect", 64'(redirect_pc), 64'd0);

    // Single correct branch: resolve edge, then pulse one cycle later
    push(8'h12, 1'b1, 32'h100);
    check("t1_count", 64'(count), 64'd1);
    resolve(4'd0, 1'b1);
    check("t1_no_early_pulse", 64'(upd_right), 64'd0);
    tick();
    check("t1_right", 64'(upd_right), 64'd1);
    check("t1_wrong", 64'(upd_wrong), 64'd0);
    check("t1_bht_id", 64'(upd_bht_id), 64'h12);
    check("t1_flush", 64'(flush), 64'd0);
    check("t1_count_after", 64'(count), 64'd0);
    tick();
    check("t1_pulse_one_cycle", 64'(upd_right), 64'd0);

    // Out-of-order resolution, in-order commit
    do_reset();
    push(8'h20, 1'b1, 32'h0);
    push(8'h21, 1'b1, 32'h0);
    push(8'h22, 1'b1, 32'h0);
    resolve(4'd2, 1'b1);
    resolve(4'd1, 1'b1);
    check_quiet("t2_wait1");
    tick();
    check_quiet("t2_wait2");
    check("t2_count_held", 64'(count), 64'd3);
    resolve(4'd0, 1'b1);
    check("t2_not_yet", 64'(upd_right), 64'd0);
    tick();
    check("t2_pop0_right", 64'(upd_right), 64'd1);
    check("t2_pop0_id", 64'(upd_bht_id), 64'h20);
    tick();
    check("t2_pop1_right", 64'(upd_right), 64'd1);
    check("t2_pop1_id", 64'(upd_bht_id), 64'h21);
    tick();
    check("t2_pop2_right", 64'(upd_right), 64'd1);
    check("t2_pop2_id", 64'(upd_bht_id), 64'h22);
    check("t2_count_empty", 64'(count), 64'd0);
    tick();
    check_quiet("t2_done");

    // Mispredict at head flushes everything
    do_reset();
    push(8'h30, 1'b0, 32'h2000);
    push(8'h31, 1'b0, 32'h3000);
    push(8'h32, 1'b0, 32'h4000);
    resolve(4'd0, 1'b1);
    tick();
    check("t3_wrong", 64'(upd_wrong), 64'd1);
    check("t3_right", 64'(upd_right), 64'd0);
    check("t3_flush", 64'(flush), 64'd1);
    check("t3_redirect", 64'(redirect_pc), 64'h2000);
    check("t3_bht_id", 64'(upd_bht_id), 64'h30);
    check("t3_count", 64'(count), 64'd0);
    tick();
    check_quiet("t3_after");
    check("t3_count_next", 64'(count), 64'd0);
    resolve(4'd1, 1'b0);
    tick();
    check_quiet("t3_stale_resolve");
    check("t3_tag_reset", 64'(alloc_tag), 64'd0);

    // Fill to DEPTH, reject the 17th, wrap to tag 0 after a pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("t4_tag%0d", i), 64'(alloc_tag), 64'(i));
      push(8'(i), 1'b1, 32'(i));
    end
    check("t4_full_ready", 64'(alloc_ready), 64'd0);
    check("t4_full_count", 64'(count), 64'd16);
    alloc_valid  = 1'b1;
    alloc_bht_id = 8'h99;
    alloc_pred_taken = 1'b1;
    alloc_alt_pc = 32'h9900;
    tick();
    check("t4_17th_rejected", 64'(count), 64'd16);
    resolve(4'd0, 1'b1);
    check("t4_still_full", 64'(count), 64'd16);
    tick();
    check("t4_pop_no_same_edge_push", 64'(count), 64'd15);
    check("t4_pop_id", 64'(upd_bht_id), 64'h00);
    check("t4_ready_again", 64'(alloc_ready), 64'd1);
    check("t4_wrap_tag", 64'(alloc_tag), 64'd0);
    tick();
    alloc_valid = 1'b0;
    check("t4_wrap_push_count", 64'(count), 64'd16);
    check("t4_tag_after_wrap", 64'(alloc_tag), 64'd1);

    // rdy low freezes everything
    do_reset();
    push(8'h55, 1'b1, 32'h0);
    rdy = 1'b0;
    res_valid = 1'b1;
    res_tag   = 4'd0;
    res_taken = 1'b1;
    alloc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t5_frozen_right%0d", i), 64'(upd_right), 64'd0);
      check($sformatf("t5_frozen_count%0d", i), 64'(count), 64'd1);
    end
    alloc_valid = 1'b0;
    rdy = 1'b1;
    tick();
    res_valid = 1'b0;
    check("t5_resolve_edge", 64'(upd_right), 64'd0);
    tick();
    check("t5_resume_right", 64'(upd_right), 64'd1);
    check("t5_resume_id", 64'(upd_bht_id), 64'h55);
    check("t5_resume_count", 64'(count), 64'd0);

    // Mispredict pop coinciding with a push discards the push
    do_reset();
    push(8'h40, 1'b0, 32'h500);
    push(8'h41, 1'b0, 32'h600);
    push(8'h42, 1'b0, 32'h700);
    resolve(4'd0, 1'b1);
    alloc_valid  = 1'b1;
    alloc_bht_id = 8'h77;
    tick();
    alloc_valid = 1'b0;
    check("t6_flush", 64'(flush), 64'd1);
    check("t6_redirect", 64'(redirect_pc), 64'h500);
    check("t6_push_discarded", 64'(count), 64'd0);
    check("t6_tag", 64'(alloc_tag), 64'd0);

    // Reset with 5 pending entries, head resolved and about to pop
    do_reset();
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i), 1'b1, 32'h0);
    resolve(4'd1, 1'b1);
    resolve(4'd0, 1'b1);
    rst = 1'b1;
    tick();
    check_quiet("t7_in_rst");
    check("t7_count", 64'(count), 64'd0);
    check("t7_bht_id", 64'(upd_bht_id), 64'd0);
    check("t7_redirect", 64'(redirect_pc), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet($sformatf("t7_after%0d", i));
    end
    check("t7_count_after", 64'(count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
